// File: rtl/demux_pkg.sv
// Shared constants for the 2-to-1 demux slice.
// Counter width, saturation value, default data width, saturating increment.
package demux_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;
  localparam int DEF_WIDTH = 1;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/demux_2_to_1_core.sv
// Combinational 2-to-1 routing: S=0 -> Y0=I, S=1 -> Y1=I.
// Ports: S select, I data in, Y1/Y0 data out (unselected side is zero).
module demux_2_to_1_core
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             S,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y0
);

  // An unknown select matches neither arm, so both
  // outputs stay at their zero defaults.
  always_comb begin
    Y0 = '0;
    Y1 = '0;
    case (S)
      1'b0: Y0 = I;
      1'b1: Y1 = I;
      default: ;
    endcase
  end

endmodule

// File: rtl/demux_2_to_1.sv
// 2-to-1 demux with optional output register and per-route counters.
// Ports: clk, rst_n, S, I, clr in; Y1, Y0, cnt0, cnt1 out.
module demux_2_to_1
  import demux_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             S,
  input  logic [WIDTH-1:0] I,
  input  logic             clr,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y0,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic [WIDTH-1:0] y1_c;
  logic [WIDTH-1:0] y0_c;
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  demux_2_to_1_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .S  (S),
    .I  (I),
    .Y1 (y1_c),
    .Y0 (y0_c)
  );

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] y1_q;
    logic [WIDTH-1:0] y0_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        y1_q <= '0;
        y0_q <= '0;
      end else begin
        y1_q <= y1_c;
        y0_q <= y0_c;
      end
    end

    assign Y1 = y1_q;
    assign Y0 = y0_q;
  end else begin : g_comb
    assign Y1 = y1_c;
    assign Y0 = y0_c;
  end

  // clr wins over increment; an unknown select counts nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (clr) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      case (S)
        1'b0: cnt0_q <= sat_inc(cnt0_q);
        1'b1: cnt1_q <= sat_inc(cnt1_q);
        default: ;
      endcase
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;

endmodule

// File: tb/tb_demux_2_to_1.sv
// Directed self-checking bench for demux_2_to_1.
// Three instances: W=1 registered, W=1 combinational, W=8 registered.
module tb_demux_2_to_1;

  logic       clk;
  logic       rst_n;
  logic       S;
  logic       clr;
  logic [0:0] i1;
  logic [7:0] i8;

  logic [0:0] r_y1, r_y0, c_y1, c_y0;
  logic [7:0] w_y1, w_y0;
  logic [7:0] r_cnt0, r_cnt1, c_cnt0, c_cnt1;
  logic [7:0] w_cnt0, w_cnt1;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] t_s  = 4'b1100;
  logic [3:0] t_i  = 4'b1010;
  logic [3:0] t_y1 = 4'b1000;
  logic [3:0] t_y0 = 4'b0010;
  logic       xprobe;

  demux_2_to_1 #(.WIDTH(1), .REG_OUT(1'b1)) u_r (
    .clk(clk), .rst_n(rst_n), .S(S), .I(i1), .clr(clr),
    .Y1(r_y1), .Y0(r_y0), .cnt0(r_cnt0), .cnt1(r_cnt1)
  );

  demux_2_to_1 #(.WIDTH(1), .REG_OUT(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .S(S), .I(i1), .clr(clr),
    .Y1(c_y1), .Y0(c_y0), .cnt0(c_cnt0), .cnt1(c_cnt1)
  );

  demux_2_to_1 #(.WIDTH(8), .REG_OUT(1'b1)) u_w (
    .clk(clk), .rst_n(rst_n), .S(S), .I(i8), .clr(clr),
    .Y1(w_y1), .Y0(w_y0), .cnt0(w_cnt0), .cnt1(w_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    S     = 1'b0;
    clr   = 1'b0;
    i1    = 1'b0;
    i8    = 8'h00;

    @(posedge clk);
    #1;
    check("rst_r_y0", 32'(r_y0), 32'h0);
    check("rst_r_y1", 32'(r_y1), 32'h0);
    check("rst_cnt0", 32'(r_cnt0), 32'h0);
    check("rst_cnt1", 32'(r_cnt1), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      S  = t_s[k];
      i1 = t_i[k];
      #1;
      check($sformatf("comb_y1_%0d", k), 32'(c_y1), 32'(t_y1[k]));
      check($sformatf("comb_y0_%0d", k), 32'(c_y0), 32'(t_y0[k]));
      check($sformatf("reg_hold_y1_%0d", k), 32'(r_y1),
            32'(k == 0 ? 1'b0 : t_y1[k-1]));
      check($sformatf("reg_hold_y0_%0d", k), 32'(r_y0),
            32'(k == 0 ? 1'b0 : t_y0[k-1]));
      @(posedge clk);
      #1;
      check($sformatf("reg_y1_%0d", k), 32'(r_y1), 32'(t_y1[k]));
      check($sformatf("reg_y0_%0d", k), 32'(r_y0), 32'(t_y0[k]));
    end

    @(negedge clk);
    S  = 1'b1;
    i8 = 8'hA5;
    @(posedge clk);
    #1;
    check("w8_s1_y1", 32'(w_y1), 32'hA5);
    check("w8_s1_y0", 32'(w_y0), 32'h00);
    @(negedge clk);
    S = 1'b0;
    @(posedge clk);
    #1;
    check("w8_s0_y0", 32'(w_y0), 32'hA5);
    check("w8_s0_y1", 32'(w_y1), 32'h00);
    @(negedge clk);
    i8 = 8'h81;
    @(posedge clk);
    #1;
    check("w8_bits_y0", 32'(w_y0), 32'h81);

    @(negedge clk);
    clr = 1'b1;
    S   = 1'b1;
    @(posedge clk);
    #1;
    check("clr_cnt0", 32'(r_cnt0), 32'h0);
    check("clr_cnt1", 32'(r_cnt1), 32'h0);
    @(negedge clk);
    clr = 1'b0;
    repeat (254) @(posedge clk);
    #1;
    check("cnt1_254", 32'(r_cnt1), 32'd254);
    @(posedge clk);
    #1;
    check("cnt1_255", 32'(r_cnt1), 32'd255);
    repeat (45) @(posedge clk);
    #1;
    check("cnt1_sat", 32'(r_cnt1), 32'd255);
    check("cnt0_idle", 32'(r_cnt0), 32'd0);

    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    check("clr_pri_cnt1", 32'(r_cnt1), 32'h0);
    check("clr_pri_cnt0", 32'(r_cnt0), 32'h0);
    @(negedge clk);
    clr = 1'b0;
    S   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("cnt0_3", 32'(r_cnt0), 32'd3);
    check("cnt1_0", 32'(r_cnt1), 32'd0);

    @(negedge clk);
    S  = 1'b0;
    i1 = 1'b1;
    @(posedge clk);
    #1;
    check("pre_rst_y0", 32'(r_y0), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_y0", 32'(r_y0), 32'h0);
    check("async_y1", 32'(r_y1), 32'h0);
    check("async_cnt0", 32'(r_cnt0), 32'h0);
    check("async_cnt1", 32'(r_cnt1), 32'h0);
    check("async_w_y0", 32'(w_y0), 32'h00);
    check("comb_in_rst", 32'(c_y0), 32'h1);
    @(posedge clk);
    #1;
    check("rst_hold_y0", 32'(r_y0), 32'h0);
    @(negedge clk);
    S     = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("fresh_y1", 32'(r_y1), 32'h1);
    check("fresh_y0", 32'(r_y0), 32'h0);
    check("fresh_cnt1", 32'(r_cnt1), 32'd1);

    @(negedge clk);
    S  = 1'bx;
    i1 = 1'b0;
    i8 = 8'h00;
    #1;
    check("x_comb_y0", 32'(c_y0), 32'h0);
    check("x_comb_y1", 32'(c_y1), 32'h0);
    @(posedge clk);
    #1;
    check("x_reg_y0", 32'(r_y0), 32'h0);
    check("x_reg_y1", 32'(r_y1), 32'h0);

    // Only a four-state simulator keeps S unknown, so
    // only there does a non-zero I test the X path.
    xprobe = 1'bx;
    if (xprobe !== 1'b0 && xprobe !== 1'b1) begin
      @(negedge clk);
      i1 = 1'b1;
      i8 = 8'hFF;
      #1;
      check("x4_comb_y0", 32'(c_y0), 32'h0);
      check("x4_comb_y1", 32'(c_y1), 32'h0);
      @(posedge clk);
      #1;
      check("x4_w_y0", 32'(w_y0), 32'h00);
      check("x4_w_y1", 32'(w_y1), 32'h00);
    end

    @(negedge clk);
    S  = 1'b0;
    i1 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/demux_2_to_1.md
DEMUX_2_TO_1 -- requirements
Module: demux_2_to_1

Interface
REQ-001 Parameter WIDTH, default 1: data width of I, Y0 and Y1.
REQ-002 Parameter REG_OUT, default 1: 1 = registered outputs; 0 = combinational data path.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 S  input  1  select; 0 routes I to Y0, 1 routes I to Y1.
REQ-006 I  input  WIDTH  data input.
REQ-007 clr  input  1  synchronous clear of both route counters.
REQ-008 Y1  output  WIDTH  data output for S=1.
REQ-009 Y0  output  WIDTH  data output for S=0.
REQ-010 cnt0  output  8  saturating count of cycles with S=0.
REQ-011 cnt1  output  8  saturating count of cycles with S=1.

Function
REQ-012 Routing: S=0 -> Y0=I, Y1=0; S=1 -> Y1=I, Y0=0.
REQ-013 The unselected output is driven to all-zeros, never held or left floating.
REQ-014 In simulation, S equal to X or Z drives both Y0 and Y1 to all-zeros.
REQ-015 REG_OUT=1: Y0 and Y1 reflect S and I sampled at the previous rising edge (1-cycle latency).
REQ-016 REG_OUT=0: Y0 and Y1 follow S and I combinationally (0-cycle latency); clk and rst_n do not affect them.
REQ-017 Each rising edge with clr=0 and S=0 increments cnt0 by 1; with S=1 it increments cnt1 by 1.
REQ-018 Counters saturate at 255 and hold at 255 until clear or reset.
REQ-019 clr=1 at a rising edge sets both counters to 0; clr has priority over increment in the same cycle.
REQ-020 Counters are always registered, independent of REG_OUT.
REQ-021 Bits of I are routed bit-for-bit with no arithmetic, reordering or sign handling.

Reset
REQ-022 rst_n=0 asynchronously forces cnt0=0 and cnt1=0.
REQ-023 With REG_OUT=1, rst_n=0 also asynchronously forces Y0=0 and Y1=0.
REQ-024 Reset asserted mid-operation discards any in-flight registered data.
REQ-025 After rst_n deasserts, the first rising edge captures fresh S and I.

Structure
REQ-026 Package demux_pkg holds CNT_W=8, the counter saturation value 255, and the default WIDTH.
REQ-027 One combinational sub-module, demux_2_to_1_core (S, I -> Y1, Y0), implements the routing.
REQ-028 The top module adds the optional output register stage and the counters around demux_2_to_1_core.

Verification
REQ-029 Truth-table sweep, WIDTH=1, REG_OUT=1, 10-time-unit steps (S,I) = (0,0),(0,1),(1,0),(1,1) -> one cycle later (Y1,Y0) = (0,0),(0,1),(0,0),(1,0).
REQ-030 REG_OUT=0 with the same sweep -> (Y1,Y0) values as REQ-029 with zero latency.
REQ-031 WIDTH=8: S=1, I=8'hA5 -> Y1=8'hA5, Y0=8'h00; then S=0 -> Y0=8'hA5, Y1=8'h00.
REQ-032 Hold S=1 for 300 cycles -> cnt1=255 and cnt0 unchanged; then clr=1 for one cycle -> both counters 0.
REQ-033 Assert rst_n=0 between clock edges while Y0=1 -> Y0, Y1, cnt0 and cnt1 read 0 immediately, without waiting for a clock edge.
REQ-034 S driven X in simulation -> Y0=0 and Y1=0.
